// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Segment vectors are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam int         MAX_DIGITS = 8;

    // Marks digits that sit above the most significant nonzero nibble; digit 0 is never marked.
    function automatic logic [MAX_DIGITS-1:0] leading_zero_mask(
        input logic [4*MAX_DIGITS-1:0] nibbles,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen_nonzero;
        mask         = '0;
        seen_nonzero = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < num_digits) begin
                if (nibbles[4*i +: 4] != 4'h0) begin
                    seen_nonzero = 1'b1;
                end
                if (!seen_nonzero && (i != 0)) begin
                    mask[i] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_segment_scan_controller_decoder.sv
// Hex nibble to active-low seven-segment glyph decoder (combinational).
// A disabled decoder drives all segments off.
module SevenSegmentsDisplayController
    import seven_seg_pkg::*;
(
    input  logic       enable,
    input  logic [3:0] hexValue,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_OFF;
        if (enable) begin
            case (hexValue)
                4'h0:    segments = 7'b1000000;
                4'h1:    segments = 7'b1111001;
                4'h2:    segments = 7'b0100100;
                4'h3:    segments = 7'b0110000;
                4'h4:    segments = 7'b0011001;
                4'h5:    segments = 7'b0010010;
                4'h6:    segments = 7'b0000010;
                4'h7:    segments = 7'b1111000;
                4'h8:    segments = 7'b0000000;
                4'h9:    segments = 7'b0010000;
                4'hA:    segments = 7'b0001000;
                4'hB:    segments = 7'b0000011;
                4'hC:    segments = 7'b1000110;
                4'hD:    segments = 7'b0100001;
                4'hE:    segments = 7'b0000110;
                4'hF:    segments = 7'b0001110;
                default: segments = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan driver for NUM_DIGITS common-anode digits on a shared segment bus,
// with dead time, leading-zero blanking, blink and tear-free frame updates.
module seven_segment_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] dataInput,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digitEnable,
    input  logic                    blankLeadingZeros,
    input  logic                    blinkEnable,
    output logic [6:0]              segmentOutput,
    output logic [NUM_DIGITS-1:0]   digitSelect,
    output logic                    frameDone
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [CW-1:0]           cnt_reg,      cnt_next;
    logic [IW-1:0]           idx_reg,      idx_next;
    logic [4*NUM_DIGITS-1:0] pending_reg,  pending_next;
    logic [4*NUM_DIGITS-1:0] active_reg,   active_next;
    logic [FW-1:0]           fcount_reg,   fcount_next;
    logic                    hidden_reg,   hidden_next;
    logic [6:0]              seg_reg,      seg_next;
    logic [NUM_DIGITS-1:0]   sel_reg,      sel_next;
    logic                    done_reg,     done_next;

    logic                    tc;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    suppress;
    logic                    dead;
    logic [3:0]              nibble_sel;
    logic [6:0]              decoded;
    logic [3:0]              nibbles [NUM_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            assign nibbles[gi] = active_next[4*gi +: 4];
        end
    endgenerate

    assign nibble_sel = nibbles[idx_next];

    SevenSegmentsDisplayController u_decoder (
        .enable   (1'b1),
        .hexValue (nibble_sel),
        .segments (decoded)
    );

    // Outputs are computed from next-state values so they line up with the counter they describe.
    always_comb begin
        tc   = (cnt_reg == CW'(SCAN_DIV - 1));
        wrap = tc && (idx_reg == IW'(NUM_DIGITS - 1));

        cnt_next = tc ? '0 : cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (tc) begin
            idx_next = wrap ? '0 : idx_reg + 1'b1;
        end

        pending_next = load ? dataInput : pending_reg;
        active_next  = wrap ? pending_next : active_reg;

        fcount_next = fcount_reg;
        hidden_next = hidden_reg;
        if (done_reg) begin
            if (fcount_reg == FW'(BLINK_FRAMES - 1)) begin
                fcount_next = '0;
                hidden_next = ~hidden_reg;
            end else begin
                fcount_next = fcount_reg + 1'b1;
            end
        end

        lz_mask  = NUM_DIGITS'(leading_zero_mask((4*MAX_DIGITS)'(active_next), NUM_DIGITS));
        suppress = !digitEnable[idx_next]
                 || (blankLeadingZeros && lz_mask[idx_next])
                 || (blinkEnable && hidden_next);
        dead     = (cnt_next < CW'(DEAD_CYCLES));

        seg_next = SEG_OFF;
        sel_next = '1;
        if (!dead && !suppress) begin
            seg_next           = decoded;
            sel_next[idx_next] = 1'b0;
        end

        done_next = wrap;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            pending_reg <= '0;
            active_reg  <= '0;
            fcount_reg  <= '0;
            hidden_reg  <= 1'b0;
            seg_reg     <= SEG_OFF;
            sel_reg     <= '1;
            done_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
            active_reg  <= active_next;
            fcount_reg  <= fcount_next;
            hidden_reg  <= hidden_next;
            seg_reg     <= seg_next;
            sel_reg     <= sel_next;
            done_reg    <= done_next;
        end
    end

    assign segmentOutput = seg_reg;
    assign digitSelect   = sel_reg;
    assign frameDone     = done_reg;

endmodule
